// File: rtl/wb_master_if.sv
// Wishbone B3 classic-cycle master: turns single-word pipeline requests into
// one outstanding bus cycle, stalling the pipeline until ack, flush or timeout.
`timescale 1ns/1ps
module wb_master_if #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        stall_req_o,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        err_o,
    input  logic [31:0] wishbone_data_i,
    input  logic        wishbone_ack_i,
    output logic [31:0] wishbone_addr_o,
    output logic [31:0] wishbone_data_o,
    output logic        wishbone_we_o,
    output logic [3:0]  wishbone_sel_o,
    output logic        wishbone_stb_o,
    output logic        wishbone_cyc_o
);

    typedef enum logic [1:0] {IDLE, BUSY, WAIT_FOR_STALL} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [31:0] rd_buf;

    logic start, busy, cnt_last, timeout, end_cyc;

    assign start    = cpu_ce_i & ~flush_i;
    assign busy     = (state == BUSY);
    assign cnt_last = (cnt == CNT_LAST);
    assign timeout  = busy & ~wishbone_ack_i & ~flush_i & cnt_last;
    // Any of ack, flush or the last timeout cycle ends the bus cycle.
    assign end_cyc  = busy & (wishbone_ack_i | flush_i | cnt_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            rd_buf          <= '0;
            err_o           <= 1'b0;
            wishbone_addr_o <= '0;
            wishbone_data_o <= '0;
            wishbone_we_o   <= 1'b0;
            wishbone_sel_o  <= '0;
            wishbone_stb_o  <= 1'b0;
            wishbone_cyc_o  <= 1'b0;
        end else begin
            err_o <= 1'b0;

            // Bus outputs: load on issue, hold through BUSY, zero everywhere else.
            if (state == IDLE && start) begin
                wishbone_addr_o <= cpu_addr_i;
                wishbone_data_o <= cpu_data_i;
                wishbone_we_o   <= cpu_we_i;
                wishbone_sel_o  <= cpu_sel_i;
                wishbone_stb_o  <= 1'b1;
                wishbone_cyc_o  <= 1'b1;
            end else if (!busy || end_cyc) begin
                wishbone_addr_o <= '0;
                wishbone_data_o <= '0;
                wishbone_we_o   <= 1'b0;
                wishbone_sel_o  <= '0;
                wishbone_stb_o  <= 1'b0;
                wishbone_cyc_o  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (wishbone_ack_i) begin
                        if (!wishbone_we_o)
                            rd_buf <= wishbone_data_i;
                        state <= stall_i ? WAIT_FOR_STALL : IDLE;
                    end else if (flush_i) begin
                        rd_buf <= '0;
                        state  <= IDLE;
                    end else if (cnt_last) begin
                        rd_buf <= '0;
                        err_o  <= 1'b1;
                        state  <= stall_i ? WAIT_FOR_STALL : IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WAIT_FOR_STALL: begin
                    if (flush_i) begin
                        rd_buf <= '0;
                        state  <= IDLE;
                    end else if (!stall_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data is forwarded combinationally in the ack cycle.
    always_comb begin
        stall_req_o = 1'b0;
        cpu_data_o  = '0;
        case (state)
            IDLE: stall_req_o = start;
            BUSY: begin
                stall_req_o = ~(wishbone_ack_i | timeout);
                if (wishbone_ack_i && !wishbone_we_o)
                    cpu_data_o = wishbone_data_i;
            end
            WAIT_FOR_STALL: cpu_data_o = rd_buf;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_master_if.sv
// Self-checking bench for wb_master_if: directed scenarios plus randomized
// transactions, checked per cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_wb_master_if;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce_i, cpu_we_i, stall_i, flush_i, wishbone_ack_i;
    logic [31:0] cpu_addr_i, cpu_data_i, wishbone_data_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_o, wishbone_addr_o, wishbone_data_o;
    logic        stall_req_o, err_o, wishbone_we_o, wishbone_stb_o, wishbone_cyc_o;
    logic [3:0]  wishbone_sel_o;

    int checks = 0;
    int failures = 0;
    logic [31:0] rdbuf;  // model of the last returned read data

    wb_master_if #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
        .stall_req_o(stall_req_o), .stall_i(stall_i), .flush_i(flush_i), .err_o(err_o),
        .wishbone_data_i(wishbone_data_i), .wishbone_ack_i(wishbone_ack_i),
        .wishbone_addr_o(wishbone_addr_o), .wishbone_data_o(wishbone_data_o),
        .wishbone_we_o(wishbone_we_o), .wishbone_sel_o(wishbone_sel_o),
        .wishbone_stb_o(wishbone_stb_o), .wishbone_cyc_o(wishbone_cyc_o)
    );

    always #5 clk = ~clk;

    logic [70:0] bus_v;
    assign bus_v = {wishbone_cyc_o, wishbone_stb_o, wishbone_we_o, wishbone_sel_o,
                    wishbone_addr_o, wishbone_data_o};

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        cpu_ce_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_sel_i = 0; cpu_data_i = 0;
        stall_i = 0; flush_i = 0; wishbone_ack_i = 0; wishbone_data_i = 0;
    endtask

    // One request from IDLE. d: BUSY cycle index of the ack (>=T never acks),
    // flush_at: BUSY cycle index of a flush pulse (-1 none), nstall: WAIT cycles.
    task automatic do_xfer(input string nm, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] sel, input int d,
                           input logic [31:0] rdata, input int nstall, input int flush_at);
        int k, kind, w;
        logic ack_now, term, exp_sr;
        logic [31:0] exp_cd;
        logic [70:0] exp_bus;
        cpu_ce_i = 1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = wd; cpu_sel_i = sel;
        flush_i = 0; stall_i = 0; wishbone_ack_i = 0;
        #1;
        checks++;
        if (stall_req_o !== 1'b1 || wishbone_cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL %s issue: stall_req=%b cyc=%b, want 1 0", nm, stall_req_o, wishbone_cyc_o);
        end
        tick();
        // Pipeline-side garbage while busy must not reach the bus.
        cpu_ce_i = 0; cpu_we_i = 1'($urandom); cpu_addr_i = $urandom; cpu_data_i = $urandom;
        cpu_sel_i = 4'($urandom);
        exp_bus = {1'b1, 1'b1, we, sel, addr, wd};
        k = 0; kind = 0; term = 0;
        while (!term) begin
            ack_now = (k == d);
            wishbone_ack_i = ack_now;
            wishbone_data_i = ack_now ? rdata : $urandom;
            flush_i = (k == flush_at);
            stall_i = (nstall > 0);
            exp_sr = !(ack_now || (k == T-1 && k != flush_at));
            exp_cd = (ack_now && !we) ? rdata : 32'h0;
            #1;
            checks++;
            if (bus_v !== exp_bus || err_o !== 1'b0) begin
                failures++;
                $display("FAIL %s busy%0d bus: got %h err=%b, want %h err=0", nm, k, bus_v, err_o, exp_bus);
            end
            checks++;
            if (stall_req_o !== exp_sr || cpu_data_o !== exp_cd) begin
                failures++;
                $display("FAIL %s busy%0d cpu: got sr=%b data=%h, want sr=%b data=%h",
                         nm, k, stall_req_o, cpu_data_o, exp_sr, exp_cd);
            end
            term = ack_now || (k == flush_at) || (k == T-1);
            kind = ack_now ? 0 : (k == flush_at) ? 1 : 2;
            tick();
            k++;
        end
        wishbone_ack_i = 0; flush_i = 0; wishbone_data_i = $urandom;
        if (kind == 0 && !we) rdbuf = rdata;
        else if (kind != 0) rdbuf = 32'h0;
        w = (kind == 1) ? 0 : nstall;
        checks++;
        if (k !== ((kind == 0) ? d + 1 : (kind == 1) ? flush_at + 1 : T)) begin
            failures++;
            $display("FAIL %s busy_len: got %0d cycles", nm, k);
        end
        for (int j = 0; j <= w; j++) begin
            stall_i = (j < w - 1);
            #1;
            checks++;
            if (bus_v !== 71'h0 || err_o !== ((j == 0) && kind == 2) || stall_req_o !== 1'b0 ||
                cpu_data_o !== ((j < w) ? rdbuf : 32'h0)) begin
                failures++;
                $display("FAIL %s post%0d: bus=%h err=%b sr=%b data=%h, want bus=0 err=%b sr=0 data=%h",
                         nm, j, bus_v, err_o, stall_req_o, cpu_data_o, (j == 0) && kind == 2,
                         (j < w) ? rdbuf : 32'h0);
            end
            tick();
        end
        stall_i = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        rdbuf = 0;
        checks++;
        if (bus_v !== 71'h0 || err_o !== 1'b0 || stall_req_o !== 1'b0 || cpu_data_o !== 32'h0) begin
            failures++;
            $display("FAIL reset: bus=%h err=%b sr=%b data=%h, want all 0", bus_v, err_o, stall_req_o, cpu_data_o);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_read();
        do_xfer("read", 1'b0, 32'h0000_0010, 32'h0, 4'hF, 1, 32'hDEAD_BEEF, 0, -1);
    endtask

    task automatic test_write();
        do_xfer("write", 1'b1, 32'h2000_0004, 32'h1234_5678, 4'b0011, 3, 32'hFFFF_FFFF, 0, -1);
    endtask

    task automatic test_read_stall();
        do_xfer("read_stall", 1'b0, 32'h0000_0100, 32'h0, 4'hF, 0, 32'hCAFE_F00D, 4, -1);
        // Write with stall leaves the earlier read data in rd_buf.
        do_xfer("write_keeps_rdbuf", 1'b1, 32'h0000_0104, 32'h5555_AAAA, 4'hF, 0, 32'h0, 2, -1);
    endtask

    task automatic test_flush();
        do_xfer("flush", 1'b0, 32'h0000_0200, 32'h0, 4'hF, 99, 32'h0, 1, 1);
        wishbone_ack_i = 1; wishbone_data_i = 32'hBAD0_BAD0;
        #1;
        checks++;
        if (bus_v !== 71'h0 || cpu_data_o !== 32'h0 || stall_req_o !== 1'b0) begin
            failures++;
            $display("FAIL late_ack: bus=%h data=%h sr=%b, want 0", bus_v, cpu_data_o, stall_req_o);
        end
        tick();
        wishbone_ack_i = 0;
        cpu_ce_i = 1; flush_i = 1;
        #1;
        checks++;
        if (stall_req_o !== 1'b0) begin
            failures++;
            $display("FAIL ce_with_flush sr: got %b want 0", stall_req_o);
        end
        tick();
        cpu_ce_i = 0; flush_i = 0;
        #1;
        checks++;
        if (wishbone_cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL ce_with_flush cyc: got %b want 0", wishbone_cyc_o);
        end
        tick();
        // rd_buf must have been cleared by the flush.
        do_xfer("rdbuf_after_flush", 1'b1, 32'h0000_0204, 32'h1, 4'h1, 0, 32'h0, 1, -1);
    endtask

    task automatic test_timeout();
        do_xfer("timeout", 1'b0, 32'h0000_0300, 32'h0, 4'hF, 99, 32'h0, 0, -1);
        do_xfer("timeout_stall", 1'b1, 32'h0000_0304, 32'h77, 4'hF, 99, 32'h0, 2, -1);
        do_xfer("ack_on_last", 1'b0, 32'h0000_0308, 32'h0, 4'hF, T-1, 32'h0BAD_CAFE, 0, -1);
    endtask

    task automatic test_ack_flush();
        do_xfer("ack_with_flush", 1'b0, 32'h0000_0400, 32'h0, 4'hF, 1, 32'h1357_9BDF, 0, 1);
    endtask

    task automatic test_mid_reset();
        cpu_ce_i = 1; cpu_we_i = 1; cpu_addr_i = 32'h0000_0500; cpu_data_i = 32'hA5A5_A5A5;
        cpu_sel_i = 4'hF;
        tick();
        cpu_ce_i = 0;
        tick();
        rst = 1;
        tick();
        rdbuf = 0;
        checks++;
        if (bus_v !== 71'h0 || err_o !== 1'b0 || stall_req_o !== 1'b0 || cpu_data_o !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset: bus=%h err=%b sr=%b data=%h, want all 0", bus_v, err_o, stall_req_o, cpu_data_o);
        end
        rst = 0;
        tick();
        do_xfer("after_reset", 1'b0, 32'h0000_0504, 32'h0, 4'hC, 2, 32'h2468_ACE0, 0, -1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            do_xfer("random", 1'($urandom), $urandom, $urandom, 4'($urandom),
                    int'($urandom_range(0, 5)), $urandom, int'($urandom_range(0, 2)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_read();
        test_write();
        test_read_stall();
        test_flush();
        test_timeout();
        test_ack_flush();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_master_if.md
# wb_master_if

Wishbone B3 classic-cycle master interface converting single-word CPU pipeline memory requests (instruction fetch or data load/store) into Wishbone bus cycles toward the wb_conmax_top master ports. It is the initiator counterpart of the BRAM and decoder slave wrappers. One instance serves the instruction port and one serves the data port. While a bus cycle is outstanding it holds the pipeline stalled, returns read data, and aborts cleanly on pipeline flush or bus timeout.

## Interface
- TIMEOUT_CYCLES, 255: BUSY cycles without ack before the cycle is forcibly terminated; 1..255.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_ce_i  in  1  request valid from pipeline.
- cpu_we_i  in  1  1 = write, 0 = read.
- cpu_addr_i  in  32  byte address; driven unmodified onto the bus.
- cpu_sel_i  in  4  byte lane enables.
- cpu_data_i  in  32  write data.
- cpu_data_o  out  32  read data to pipeline.
- stall_req_o  out  1  pipeline must hold.
- stall_i  in  1  pipeline is stalled by another source.
- flush_i  in  1  pipeline flush (exception or eret).
- err_o  out  1  one-cycle pulse on timeout.
- wishbone_data_i  in  32  slave read data.
- wishbone_ack_i  in  1  slave acknowledge.
- wishbone_addr_o  out  32  bus address.
- wishbone_data_o  out  32  bus write data.
- wishbone_we_o  out  1  bus write enable.
- wishbone_sel_o  out  4  bus byte select.
- wishbone_stb_o  out  1  strobe.
- wishbone_cyc_o  out  1  cycle.

## Operation
- States: IDLE, BUSY, WAIT_FOR_STALL. The reset state is IDLE.
- IDLE:
  - If cpu_ce_i=1 and flush_i=0, register addr, data, we and sel onto the bus, set cyc=stb=1, clear the timeout counter and go to BUSY.
  - Otherwise all bus outputs are 0.
- BUSY, ack=1 (takes precedence over timeout):
  - Deassert cyc, stb and we; zero addr, data and sel.
  - On a read, capture wishbone_data_i into rd_buf.
  - Go to WAIT_FOR_STALL if stall_i=1, else IDLE.
- BUSY, flush_i=1 and ack=0:
  - Deassert cyc and stb immediately (registered, next edge); zero all bus outputs.
  - Set rd_buf=0 and go to IDLE.
  - No data is returned.
- BUSY, counter reaches TIMEOUT_CYCLES-1 with ack=0 and flush=0:
  - Terminate the cycle as for flush.
  - Pulse err_o for 1 cycle and set rd_buf=0.
  - Go to WAIT_FOR_STALL if stall_i=1, else IDLE.
- BUSY otherwise: increment the 8-bit counter and hold all bus outputs stable (Wishbone rule: signals constant until ack).
- WAIT_FOR_STALL: bus outputs are 0. Go to IDLE when stall_i=0. flush_i=1 also forces IDLE with rd_buf=0.
- stall_req_o and cpu_data_o are combinational:
  - IDLE: stall_req_o = cpu_ce_i & ~flush_i; cpu_data_o = 0.
  - BUSY with ack=1 (or timeout): stall_req_o=0. cpu_data_o = wishbone_data_i on a read with ack, else 0.
  - BUSY otherwise: stall_req_o=1, cpu_data_o=0.
  - WAIT_FOR_STALL: stall_req_o=0, cpu_data_o=rd_buf.
- A write never updates rd_buf.
- The block issues at most one outstanding cycle, with no pipelining or burst.

## Timing
- Reset: state=IDLE, every output 0, rd_buf=0, counter=0. This includes err_o.
- A reset asserted mid-cycle drops cyc/stb on the next edge without waiting for ack.
- Latency:
  - Request seen at edge N gives cyc/stb=1 after edge N.
  - With the slave acking in the same cycle (combinational ack), data returns in that cycle and the request completes in 2 cycles.
  - A registered-ack slave such as the BRAM wrapper takes 3 cycles.
- After ack, cyc=0 for at least 1 cycle before the next cycle starts (IDLE re-entry).
- Ack arriving in the same cycle as flush: ack wins and data is captured. The pipeline discards it.
- Ack is ignored when cyc=0.
- Timeout fires on the TIMEOUT_CYCLES-th BUSY cycle with no ack.

## Test plan
- Read, 1-cycle-delayed ack, data 0xDEADBEEF at addr 0x0000_0010:
  - Required: cyc/stb high for 2 cycles, we=0, sel=1111.
  - Required: stall_req_o falls in the ack cycle, cpu_data_o=0xDEADBEEF.
- Write 0x1234_5678, sel=0011, addr 0x2000_0004, ack after 3 cycles:
  - Required: bus signals stable until ack, we=1.
  - Required: cyc=0 the next cycle, cpu_data_o=0.
- Read acked while stall_i=1 for 4 more cycles:
  - Required: state WAIT_FOR_STALL, stall_req_o=0, cpu_data_o held at rd_buf until stall_i falls, then IDLE.
- flush_i in the 2nd BUSY cycle with no ack:
  - Required: cyc/stb=0 next cycle, no err_o, rd_buf=0.
  - Required: a late ack is ignored.
- TIMEOUT_CYCLES=4, slave never acks:
  - Required: cyc drops after 4 BUSY cycles, err_o pulses exactly once, stall_req_o=0 in the termination cycle, cpu_data_o=0.
- rst asserted mid-BUSY:
  - Required: all outputs 0 next edge.
  - Required: a new request after reset release completes normally.
